// File: rtl/smart_room_pkg.sv
// smart_room_pkg: shared widths, defaults and receiver state encoding for Smart-Room blocks
package smart_room_pkg;
  localparam int TEMP_W = 6;
  localparam logic [TEMP_W-1:0] DEFAULT_RESET_TEMP = 6'd25;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/temp_sensor_reader.sv
// temp_sensor_reader: deserializes framed 6-bit sensor readings and publishes only verified ones
module temp_sensor_reader
  import smart_room_pkg::*;
#(
  parameter int                CLKS_PER_BIT = 16,
  parameter logic [TEMP_W-1:0] RESET_TEMP   = DEFAULT_RESET_TEMP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sdata,
  output logic [TEMP_W-1:0] temp,
  output logic              temp_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);
  localparam logic [7:0] HALF = 8'(CLKS_PER_BIT / 2);
  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);
  rx_state_t         state;
  logic [7:0]        cnt;
  logic [2:0]        bits;
  logic [TEMP_W-1:0] shreg;
  logic              par_ok;
  logic              s;
  logic              tick;
  sync_2ff #(.RESET_VAL(1'b1)) u_sync (.clk(clk), .rst_n(rst_n), .d(sdata), .q(s));
  assign tick = cnt == LAST;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bits       <= '0;
      shreg      <= '0;
      par_ok     <= 1'b0;
      temp       <= RESET_TEMP;
      temp_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      temp_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: if (!s) begin
          state <= START;
          cnt   <= '0;
        end
        START: if (cnt == HALF) begin
          cnt   <= '0;
          bits  <= '0;
          state <= s ? IDLE : DATA;
        end else cnt <= cnt + 8'd1;
        DATA: if (tick) begin
          cnt   <= '0;
          shreg <= {shreg[TEMP_W-2:0], s};
          bits  <= bits + 3'd1;
          if (bits == 3'(TEMP_W - 1)) state <= PARITY;
        end else cnt <= cnt + 8'd1;
        PARITY: if (tick) begin
          cnt    <= '0;
          par_ok <= (^shreg ^ s) == 1'b0;
          state  <= STOP;
        end else cnt <= cnt + 8'd1;
        STOP: if (tick) begin
          cnt <= '0;
          // a broken stop bit outranks any parity verdict
          if (!s) begin
            frame_err <= 1'b1;
            state     <= WAIT_HIGH;
          end else begin
            state <= IDLE;
            if (par_ok) begin
              temp       <= shreg;
              temp_valid <= 1'b1;
            end else parity_err <= 1'b1;
          end
        end else cnt <= cnt + 8'd1;
        WAIT_HIGH: if (s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_temp_sensor_reader.sv
// tb_temp_sensor_reader: randomized scoreboard bench for the serial temperature reader
module tb_temp_sensor_reader;
  localparam int CPB = 4;
  typedef struct {int kind; int t;} exp_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sdata = 1'b1;
  logic [5:0] temp;
  logic       temp_valid, parity_err, frame_err, busy;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         model_temp = 25;
  int         prev_temp = 25;
  int         valid_times[$];
  exp_t       q[$];
  exp_t       e;
  temp_sensor_reader #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .sdata(sdata), .temp(temp),
    .temp_valid(temp_valid), .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) prev_temp = int'(temp);
    else begin
      if (!temp_valid) chk("temp_hold", int'(temp), prev_temp);
      prev_temp = int'(temp);
      if (int'(temp_valid) + int'(parity_err) + int'(frame_err) > 1)
        chk("pulse_exclusive", int'(temp_valid) + int'(parity_err) + int'(frame_err), 1);
      else if (temp_valid || parity_err || frame_err) begin
        if (q.size() == 0) chk("unexpected_pulse", temp_valid ? 0 : parity_err ? 1 : 2, 3);
        else begin
          e = q.pop_front();
          chk("pulse_kind", temp_valid ? 0 : parity_err ? 1 : 2, e.kind);
          chk("pulse_temp", int'(temp), e.t);
          chk("busy_at_pulse", int'(busy), e.kind == 2 ? 1 : 0);
          if (temp_valid) valid_times.push_back(cyc);
        end
      end
    end
  end
  task automatic send_bit(input logic b);
    sdata = b;
    repeat (CPB) @(negedge clk);
  endtask
  task automatic send_raw(input logic [5:0] d, input logic p, input logic st);
    send_bit(1'b0);
    for (int i = 5; i >= 0; i--) send_bit(d[i]);
    send_bit(p);
    send_bit(st);
  endtask
  // reference: stop fault wins, then even parity, else the reading is adopted
  task automatic send_frame(input logic [5:0] d, input logic p, input logic st);
    exp_t x;
    if (!st) x = '{2, model_temp};
    else if ((^d ^ p) != 1'b0) x = '{1, model_temp};
    else begin
      model_temp = int'(d);
      x = '{0, model_temp};
    end
    q.push_back(x);
    send_raw(d, p, st);
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
    repeat (4) @(negedge clk);
  endtask
  initial begin
    int seen;
    logic [5:0] d;
    logic bp, st;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_temp", int'(temp), 25);
    chk("reset_busy", int'(busy), 0);
    chk("reset_pulses", int'(temp_valid) + int'(parity_err) + int'(frame_err), 0);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("idle_temp", int'(temp), 25);
    chk("idle_busy", int'(busy), 0);
    chk("idle_pulses", int'(temp_valid) + int'(parity_err) + int'(frame_err), 0);
    send_frame(6'd27, 1'b0, 1'b1);
    send_bit(1'b1);
    drain();
    chk("temp_27", int'(temp), 27);
    send_frame(6'd17, 1'b1, 1'b1);
    send_bit(1'b1);
    drain();
    chk("temp_after_parity", int'(temp), 27);
    send_frame(6'd35, 1'b1, 1'b0);
    sdata = 1'b0;
    for (int i = 0; i < 10; i++) begin
      repeat (CPB) @(negedge clk);
      chk("wait_high_busy", int'(busy), 1);
    end
    send_bit(1'b1);
    send_bit(1'b1);
    chk("after_wait_busy", int'(busy), 0);
    chk("temp_after_frame_err", int'(temp), 27);
    send_frame(6'd17, 1'b0, 1'b1);
    send_bit(1'b1);
    drain();
    chk("temp_17", int'(temp), 17);
    sdata = 1'b0;
    @(negedge clk);
    sdata = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    chk("glitch_busy_seen", seen, 1);
    chk("glitch_busy_after", int'(busy), 0);
    valid_times.delete();
    send_frame(6'd20, 1'b0, 1'b1);
    send_frame(6'd21, 1'b1, 1'b1);
    send_bit(1'b1);
    drain();
    chk("b2b_count", valid_times.size(), 2);
    if (valid_times.size() == 2) chk("b2b_spacing", valid_times[1] - valid_times[0], 9 * CPB);
    chk("temp_21", int'(temp), 21);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    sdata = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midframe_reset_temp", int'(temp), 25);
    chk("midframe_reset_busy", int'(busy), 0);
    model_temp = 25;
    repeat (CPB - 2) @(negedge clk);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    rst_n = 1'b1;
    seen = 0;
    sdata = 1'b1;
    repeat (10 * CPB) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    chk("aborted_frame_busy", seen, 0);
    chk("aborted_frame_temp", int'(temp), 25);
    for (int i = 0; i < 40; i++) begin
      d  = 6'($urandom_range(63));
      bp = ($urandom_range(4) == 0);
      st = ($urandom_range(5) != 0);
      send_frame(d, ^d ^ bp, st);
      repeat (st ? $urandom_range(2) : 1 + $urandom_range(2)) send_bit(1'b1);
    end
    send_bit(1'b1);
    drain();
    chk("random_final_temp", int'(temp), model_temp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
